// File: rtl/comparator_arbiter.sv
// rtl/comparator_arbiter.sv - round-robin arbiter sharing one 8-bit magnitude comparator
// Three-cycle transaction: capture winner (IDLE), compare (CMP), present tagged result (RESP).

module comparator (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       eq,
  output logic       lt,
  output logic       gt
);

  logic hi_eq;
  logic hi_lt;
  logic lo_eq;
  logic lo_lt;

  // High nibble dominates; low nibble only breaks a high-nibble tie.
  assign hi_eq = (a[7:4] == b[7:4]);
  assign hi_lt = (a[7:4] <  b[7:4]);
  assign lo_eq = (a[3:0] == b[3:0]);
  assign lo_lt = (a[3:0] <  b[3:0]);

  assign eq = hi_eq & lo_eq;
  assign lt = hi_lt | (hi_eq & lo_lt);
  assign gt = ~eq & ~lt;

endmodule

module comparator_arbiter #(
  parameter int  NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] a_in,
  input  logic [NUM_REQ*8-1:0] b_in,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_eq,
  output logic                 rsp_lt,
  output logic                 rsp_gt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state;
  logic [ID_W-1:0] ptr;
  logic [7:0]      op_a;
  logic [7:0]      op_b;
  logic [ID_W-1:0] op_id;

  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] cand_id;
  logic [7:0]      win_a;
  logic [7:0]      win_b;

  logic            cmp_eq;
  logic            cmp_lt;
  logic            cmp_gt;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand_id   = '0;
    win_a     = '0;
    win_b     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_id = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!win_found && req[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        win_a = a_in[8*i +: 8];
        win_b = b_in[8*i +: 8];
      end
    end
  end

  comparator u_comparator (
    .a  (op_a),
    .b  (op_b),
    .eq (cmp_eq),
    .lt (cmp_lt),
    .gt (cmp_gt)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= ID_W'(NUM_REQ - 1);
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      grant     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_eq    <= 1'b0;
      rsp_lt    <= 1'b0;
      rsp_gt    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            op_a  <= win_a;
            op_b  <= win_b;
            op_id <= win_id;
            grant <= NUM_REQ'(1) << win_id;
            state <= CMP;
          end
        end
        CMP: begin
          grant     <= '0;
          rsp_valid <= 1'b1;
          rsp_id    <= op_id;
          rsp_eq    <= cmp_eq;
          rsp_lt    <= cmp_lt;
          rsp_gt    <= cmp_gt;
          state     <= RESP;
        end
        RESP: begin
          // rsp_id deliberately keeps its value after the pulse.
          rsp_valid <= 1'b0;
          rsp_eq    <= 1'b0;
          rsp_lt    <= 1'b0;
          rsp_gt    <= 1'b0;
          ptr       <= op_id;
          state     <= IDLE;
        end
        default: begin
          grant     <= '0;
          rsp_valid <= 1'b0;
          rsp_eq    <= 1'b0;
          rsp_lt    <= 1'b0;
          rsp_gt    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_arbiter.sv
// tb/tb_comparator_arbiter.sv - scoreboard bench for comparator_arbiter
module tb_comparator_arbiter;

  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  a [4];
  logic [7:0]  b [4];
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  grant;
  logic        busy;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic        rsp_eq;
  logic        rsp_lt;
  logic        rsp_gt;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int gcyc [5];
  int gc;

  logic [1:0] grant_q [$];
  logic [4:0] rsp_q [$];

  assign a_in = {a[3], a[2], a[1], a[0]};
  assign b_in = {b[3], b[2], b[1], b[0]};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comparator_arbiter #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .grant     (grant),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_eq    (rsp_eq),
    .rsp_lt    (rsp_lt),
    .rsp_gt    (rsp_gt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_txn(input logic [1:0] id, input logic [2:0] flags);
    grant_q.push_back(id);
    rsp_q.push_back({id, flags});
  endtask

  task automatic wait_grant(output int at);
    bit seen = 0;
    at = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (grant != 4'b0) begin
        seen = 1;
        at = cyc;
      end
    end
    if (!seen) check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare every grant and every response against the scoreboard.
  initial begin
    logic [1:0] eg;
    logic [4:0] er;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (grant != 4'b0) begin
          if (grant_q.size() == 0) check("unexpected_grant", {28'b0, grant}, 32'd0);
          else begin
            eg = grant_q.pop_front();
            check("grant", {28'b0, grant}, 32'(4'b0001 << eg));
          end
        end
        if (rsp_valid) begin
          if (rsp_q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
          else begin
            er = rsp_q.pop_front();
            check("rsp", {27'b0, rsp_id, rsp_eq, rsp_lt, rsp_gt}, {27'b0, er});
          end
        end else begin
          check("flags_idle", {29'b0, rsp_eq, rsp_lt, rsp_gt}, 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  typedef struct {logic [7:0] a; logic [7:0] b; logic [2:0] f;} vec_t;
  vec_t sweep [5];

  initial begin
    int t0;
    for (int i = 0; i < 4; i++) begin a[i] = 8'h00; b[i] = 8'h00; end
    rst_n = 1'b0;
    req   = 4'b0;
    #3;
    check("rst_grant", {28'b0, grant}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_outs", {27'b0, rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_gt}, 32'd0);
    do_reset();

    // 1: single request, equal operands, latency
    a[0] = 8'h5A; b[0] = 8'h5A; req = 4'b0001;
    t0 = cyc;
    expect_txn(2'd0, EQ);
    wait_grant(gc);
    check("t1_grant_latency", 32'(gc - t0), 32'd1);
    check("t1_busy", {31'b0, busy}, 32'd1);
    req = 4'b0;
    @(negedge clk);
    check("t1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    @(negedge clk);
    check("t1_rsp_drop", {31'b0, rsp_valid}, 32'd0);
    check("t1_id_hold", {30'b0, rsp_id}, 32'd0);

    // 2: all four requesting; operands give id0 eq, id1 gt, id2 lt, id3 gt
    do_reset();
    a[0] = 8'h22; b[0] = 8'h22;
    a[1] = 8'h80; b[1] = 8'h7F;
    a[2] = 8'h01; b[2] = 8'h02;
    a[3] = 8'h34; b[3] = 8'h33;
    expect_txn(2'd0, EQ); expect_txn(2'd1, GT); expect_txn(2'd2, LT);
    expect_txn(2'd3, GT); expect_txn(2'd0, EQ);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_grant(gcyc[n]);
      check("t2_busy", {31'b0, busy}, 32'd1);
      if (n > 0) check("t2_spacing", 32'(gcyc[n] - gcyc[n-1]), 32'd3);
    end
    req = 4'b0;
    repeat (4) @(negedge clk);

    // 3: req0 and req2 held -> 0,2,0,2
    do_reset();
    expect_txn(2'd0, EQ); expect_txn(2'd2, LT);
    expect_txn(2'd0, EQ); expect_txn(2'd2, LT);
    req = 4'b0101;
    for (int n = 0; n < 4; n++) wait_grant(gc);
    req = 4'b0;
    repeat (4) @(negedge clk);

    // 4: operand sweep on requester 1
    sweep[0] = '{8'h10, 8'h0F, GT};
    sweep[1] = '{8'h7F, 8'h80, LT};
    sweep[2] = '{8'h00, 8'hFF, LT};
    sweep[3] = '{8'hFF, 8'hFF, EQ};
    sweep[4] = '{8'hA3, 8'hA7, LT};
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      a[1] = sweep[n].a; b[1] = sweep[n].b; req = 4'b0010;
      expect_txn(2'd1, sweep[n].f);
      wait_grant(gc);
      req = 4'b0;
      repeat (2) @(negedge clk);
    end

    // 5: reset during CMP abandons the transaction
    @(posedge clk); #1;
    req = 4'b0001;
    grant_q.push_back(2'd0);
    wait_grant(gc);
    #2 rst_n = 1'b0;
    #1;
    check("t5_grant", {28'b0, grant}, 32'd0);
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_rsp", {27'b0, rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_gt}, 32'd0);
    req = 4'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    req = 4'b1111;
    expect_txn(2'd0, EQ);
    wait_grant(gc);
    req = 4'b0;
    repeat (3) @(negedge clk);

    // 6: req3 only during CMP/RESP; a0 changed in grant cycle
    @(posedge clk); #1;
    a[0] = 8'h20; b[0] = 8'h30; req = 4'b0001;
    expect_txn(2'd0, LT);
    wait_grant(gc);
    req = 4'b1000; a[0] = 8'h99;
    @(negedge clk);
    req = 4'b0;
    repeat (6) @(negedge clk);

    check("grant_q_empty", 32'(grant_q.size()), 32'd0);
    check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
